// File: rtl/multi_write_fifo.sv
// multi_write_fifo: packs up to NUM_WRITERS writes per cycle into a FIFO read as first-word-fall-through
module multi_write_fifo #(
  parameter int DATA_WIDTH  = 20,
  parameter int DEPTH       = 16,
  parameter int NUM_WRITERS = 4,
  parameter int AF_MARGIN   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_WRITERS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_WRITERS-1:0]            write_en,
  output logic [NUM_WRITERS-1:0]            write_accept,
  output logic                              full,
  output logic                              almost_full,
  output logic [$clog2(DEPTH+1)-1:0]        level,
  input  logic                              read_en,
  output logic                              empty,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int SW = LW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] waddr [NUM_WRITERS];
  logic [LW-1:0] free, cnt;
  logic rd;
  function automatic logic [PW-1:0] wrap(input logic [SW-1:0] s);
    return PW'(s >= SW'(DEPTH) ? s - SW'(DEPTH) : s);
  endfunction
  assign free        = LW'(DEPTH) - level;
  assign full        = level == LW'(DEPTH);
  assign empty       = level == '0;
  assign almost_full = free <= LW'(AF_MARGIN);
  assign rd          = read_en && !empty;
  assign data_out    = mem[rd_ptr];
  // cnt tracks how many lower-indexed ports already claimed a slot, which is also the slot offset
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_WRITERS; i++) begin
      write_accept[i] = write_en[i] && (cnt < free);
      waddr[i] = wrap(SW'(wr_ptr) + SW'(cnt));
      cnt = cnt + LW'(write_en[i] && (cnt < free));
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_WRITERS; i++)
      if (write_accept[i]) mem[waddr[i]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wrap(SW'(wr_ptr) + SW'(cnt));
      rd_ptr    <= rd ? (rd_ptr == PW'(DEPTH-1) ? '0 : rd_ptr + 1'b1) : rd_ptr;
      level     <= level + cnt - LW'(rd);
      underflow <= underflow | (read_en & empty);
    end
  end
endmodule

// File: tb/tb_multi_write_fifo.sv
// tb_multi_write_fifo: directed vectors with a read-data scoreboard for multi_write_fifo
module tb_multi_write_fifo;
  localparam int DW = 20, D = 8, NW = 4, AF = 2;
  logic clk = 0, reset = 1, read_en = 0;
  logic [NW*DW-1:0] data_in = '0;
  logic [NW-1:0] write_en = '0, write_accept;
  logic full, almost_full, empty, underflow;
  logic [3:0] level;
  logic [DW-1:0] data_out;
  logic [DW-1:0] sb [$];
  int n_cmp = 0, n_bad = 0;

  multi_write_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .NUM_WRITERS(NW), .AF_MARGIN(AF)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .write_en(write_en),
    .write_accept(write_accept), .full(full), .almost_full(almost_full), .level(level),
    .read_en(read_en), .empty(empty), .data_out(data_out), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // a pop happens on any clock where read_en meets a non-empty FIFO
  always @(negedge clk) begin
    if (!reset && read_en && !empty) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL read_unexpected: got %0h expected no read data", data_out);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        if (data_out !== e) begin
          n_bad++;
          $display("FAIL read_data: got %0h expected %0h", data_out, e);
        end
      end
    end
  end

  task automatic cyc(input logic [3:0] we, input logic [NW*DW-1:0] d, input logic rd,
                     input logic [3:0] exp_acc, input string nm);
    write_en = we; data_in = d; read_en = rd;
    #1;
    chk(32'(write_accept), 32'(exp_acc), nm);
    for (int i = 0; i < NW; i++) if (exp_acc[i]) sb.push_back(d[i*DW +: DW]);
    @(posedge clk); #1;
    write_en = '0; read_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk(32'(empty), 1, "rst_empty");
    chk(32'(full), 0, "rst_full");
    chk(32'(level), 0, "rst_level");
    chk(32'(underflow), 0, "rst_underflow");
    chk(32'(almost_full), 0, "rst_almost_full");
    chk(32'(write_accept), 0, "rst_accept");
    // all four ports land in port order
    cyc(4'b1111, {20'h4, 20'h3, 20'h2, 20'h1}, 0, 4'b1111, "t2_accept");
    chk(32'(level), 4, "t2_level");
    chk(32'(data_out), 32'h1, "t2_head");
    repeat (4) cyc(4'b0000, '0, 1, 4'b0000, "t2_read_accept");
    chk(32'(empty), 1, "t2_empty");
    // fill to 6, then only two slots remain for ports 0,1,3
    cyc(4'b1111, {20'h8, 20'h7, 20'h6, 20'h5}, 0, 4'b1111, "t3_fill_a");
    cyc(4'b0011, {20'h0, 20'h0, 20'hA, 20'h9}, 0, 4'b0011, "t3_fill_b");
    chk(32'(level), 6, "t3_level6");
    chk(32'(almost_full), 1, "t3_af_at6");
    cyc(4'b1011, {20'hDDDDD, 20'hCCCCC, 20'hBBBBB, 20'hAAAAA}, 0, 4'b0011, "t3_accept");
    chk(32'(level), 8, "t3_level8");
    chk(32'(full), 1, "t3_full");
    chk(32'(almost_full), 1, "t3_af");
    // read at full frees space only for the next cycle
    cyc(4'b1111, {20'h14, 20'h13, 20'h12, 20'h11}, 1, 4'b0000, "t5_accept_full");
    chk(32'(level), 7, "t5_level7");
    chk(32'(full), 0, "t5_not_full");
    chk(32'(data_out), 32'h6, "t5_head");
    cyc(4'b1111, {20'h24, 20'h23, 20'h22, 20'h21}, 0, 4'b0001, "t5_accept_next");
    chk(32'(level), 8, "t5_level8");
    repeat (8) cyc(4'b0000, '0, 1, 4'b0000, "t5_drain");
    chk(32'(empty), 1, "t5_empty");
    chk(32'(sb.size()), 0, "t5_sb_drained");
    // streaming over 20 entries wraps both pointers
    cyc(4'b0101, {20'h0, 20'h301, 20'h0, 20'h300}, 0, 4'b0101, "t4_first");
    cyc(4'b0000, '0, 1, 4'b0000, "t4_rd");
    for (int k = 1; k < 10; k++) begin
      cyc(4'b0101, {20'h0, 20'(32'h301 + 2*k), 20'h0, 20'(32'h300 + 2*k)}, 1, 4'b0101, "t4_wr");
      cyc(4'b0000, '0, 1, 4'b0000, "t4_rd");
    end
    chk(32'(level), 1, "t4_level1");
    cyc(4'b0000, '0, 1, 4'b0000, "t4_last");
    chk(32'(empty), 1, "t4_empty");
    chk(32'(sb.size()), 0, "t4_sb_drained");
    // underflow is sticky; read at empty is ignored while writes proceed
    cyc(4'b0000, '0, 1, 4'b0000, "t6_ufl_read");
    chk(32'(underflow), 1, "t6_underflow");
    chk(32'(level), 0, "t6_level0");
    cyc(4'b1111, {20'h44, 20'h43, 20'h42, 20'h41}, 1, 4'b1111, "t6_rw_empty");
    chk(32'(level), 4, "t6_level4");
    chk(32'(data_out), 32'h41, "t6_head");
    cyc(4'b0001, {20'h0, 20'h0, 20'h0, 20'h45}, 0, 4'b0001, "t6_wr5");
    chk(32'(level), 5, "t6_level5");
    chk(32'(underflow), 1, "t6_ufl_sticky");
    reset = 1; write_en = 4'b1111;
    @(posedge clk); #1;
    reset = 0; write_en = '0;
    sb.delete();
    #1;
    chk(32'(level), 0, "t6_rst_level");
    chk(32'(empty), 1, "t6_rst_empty");
    chk(32'(underflow), 0, "t6_rst_ufl");
    chk(32'(write_accept), 0, "t6_rst_accept");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
